// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- PS/2 host-to-device transmitter.
//
// Runs the full host request-to-send sequence: clock inhibit, start bit,
// 8 data bits LSB first, odd parity, stop bit, then the device ACK. All
// timing is derived from CLK_FREQ_HZ at elaboration. Both PS/2 lines are
// synchronised before use. The wrapper above owns the open-collector pads;
// this block only produces the drive enables and the data value.
//
// Optional feature macro: PS2_TX_RETRY_EN
//   defined   -> on any failure the captured byte is re-sent (new INHIBIT)
//                up to MAX_RETRIES times; ERROR only after the final failure.
//   undefined -> the first failure is reported immediately.
//
// Ports:
//   CLK             in   system clock
//   RESET           in   synchronous reset, active-high
//   CLK_PS2_IN      in   raw PS/2 clock line
//   CLK_PS2_OUT_EN  out  1 = pull the clock line low
//   DATA_PS2_IN     in   raw PS/2 data line
//   DATA_PS2_OUT    out  data value driven while DATA_PS2_OUT_EN is high
//   DATA_PS2_OUT_EN out  1 = drive the data line
//   SEND_BYTE       in   single-cycle request, honoured only in IDLE
//   BYTE_TO_SEND    in   byte captured with an accepted request
//   BUSY            out  high in every state except IDLE
//   BYTE_SENT       out  one-cycle pulse on a successful ACK
//   ERROR           out  one-cycle pulse on failure
//   ERR_CODE        out  01 start timeout, 10 frame timeout, 11 NACK

module ps2_host_tx #(
  parameter int CLK_FREQ_HZ      = 100_000_000,
  parameter int INHIBIT_US       = 100,
  parameter int START_TIMEOUT_US = 15000,
  parameter int FRAME_TIMEOUT_US = 2000,
  parameter int SYNC_STAGES      = 2,
  parameter int MAX_RETRIES      = 3
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CLK_PS2_IN,
  output logic       CLK_PS2_OUT_EN,
  input  logic       DATA_PS2_IN,
  output logic       DATA_PS2_OUT,
  output logic       DATA_PS2_OUT_EN,
  input  logic       SEND_BYTE,
  input  logic [7:0] BYTE_TO_SEND,
  output logic       BUSY,
  output logic       BYTE_SENT,
  output logic       ERROR,
  output logic [1:0] ERR_CODE
);

  localparam int CYC_PER_US = CLK_FREQ_HZ / 1_000_000;
  localparam int INH_CNT    = CYC_PER_US * INHIBIT_US;
  localparam int START_CNT  = CYC_PER_US * START_TIMEOUT_US;
  localparam int FRAME_CNT  = CYC_PER_US * FRAME_TIMEOUT_US;
  localparam int MAX_A      = (INH_CNT > START_CNT) ? INH_CNT : START_CNT;
  localparam int MAX_CNT    = (MAX_A > FRAME_CNT) ? MAX_A : FRAME_CNT;
  localparam int CW         = $clog2(MAX_CNT + 1);
  localparam int SS         = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  localparam logic [CW-1:0] INH_LAST   = CW'(INH_CNT - 1);
  localparam logic [CW-1:0] START_LAST = CW'(START_CNT - 1);
  localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_CNT - 1);

  localparam logic [1:0] ERR_START = 2'b01;
  localparam logic [1:0] ERR_FRAME = 2'b10;
  localparam logic [1:0] ERR_NACK  = 2'b11;

`ifdef PS2_TX_RETRY_EN
  localparam int RW0 = $clog2(MAX_RETRIES + 1);
  localparam int RW  = (RW0 < 2) ? 2 : RW0;
`endif

  typedef enum logic [3:0] {
    ST_IDLE, ST_INHIBIT, ST_REQ, ST_WAIT_START, ST_DATA,
    ST_PARITY, ST_STOP, ST_ACK_WAIT, ST_ACK_RELEASE
  } state_t;

  // odd parity bit for a data byte
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  logic [SS-1:0] r_clk_sync;
  logic [SS-1:0] r_data_sync;
  logic          r_clk_prev;
  logic          w_clk_s;
  logic          w_data_s;
  logic          w_fe;

  state_t        r_state, w_state_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic [3:0]    r_idx, w_idx_nx;
  logic [7:0]    r_byte, w_byte_nx;
  logic          r_par, w_par_nx;
  logic          r_clk_en, r_data_out, r_data_en, r_busy, r_sent, r_error;
  logic          w_data_out_nx, w_data_en_nx, w_sent_nx, w_error_nx;
  logic [1:0]    r_err_code, w_err_code_nx;
  logic          w_fail;
  logic [1:0]    w_fail_code;
  logic          w_frame_to;

`ifdef PS2_TX_RETRY_EN
  logic [RW-1:0] r_retry, w_retry_nx;
`else
  logic          w_unused_retries;
  assign w_unused_retries = (MAX_RETRIES > 0);
`endif

  assign w_clk_s    = r_clk_sync[SS-1];
  assign w_data_s   = r_data_sync[SS-1];
  assign w_fe       = r_clk_prev & ~w_clk_s;
  assign w_frame_to = (r_cnt == FRAME_LAST);

  // input synchronisers; reset to the idle-high line level so no false edge appears
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_clk_sync  <= {SS{1'b1}};
      r_data_sync <= {SS{1'b1}};
      r_clk_prev  <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[SS-2:0], CLK_PS2_IN};
      r_data_sync <= {r_data_sync[SS-2:0], DATA_PS2_IN};
      r_clk_prev  <= w_clk_s;
    end
  end

  // next-state, counter and output-value logic
  always_comb begin
    w_state_nx    = r_state;
    w_cnt_nx      = r_cnt;
    w_idx_nx      = r_idx;
    w_byte_nx     = r_byte;
    w_par_nx      = r_par;
    w_data_out_nx = r_data_out;
    w_data_en_nx  = r_data_en;
    w_sent_nx     = 1'b0;
    w_error_nx    = 1'b0;
    w_err_code_nx = r_err_code;
    w_fail        = 1'b0;
    w_fail_code   = 2'b00;
`ifdef PS2_TX_RETRY_EN
    w_retry_nx    = r_retry;
`endif

    case (r_state)
      ST_IDLE: begin
        w_data_en_nx  = 1'b0;
        w_data_out_nx = 1'b0;
        if (SEND_BYTE) begin
          w_byte_nx     = BYTE_TO_SEND;
          w_par_nx      = odd_parity(BYTE_TO_SEND);
          w_err_code_nx = 2'b00;
          w_cnt_nx      = '0;
          w_state_nx    = ST_INHIBIT;
`ifdef PS2_TX_RETRY_EN
          w_retry_nx    = '0;
`endif
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_INHIBIT: begin
        if (r_cnt == INH_LAST) begin
          w_cnt_nx      = '0;
          w_data_en_nx  = 1'b1;
          w_data_out_nx = 1'b0;
          w_state_nx    = ST_REQ;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      ST_REQ: begin
        w_cnt_nx   = '0;
        w_state_nx = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        // timeout checked first so it wins over a coincident edge
        if (r_cnt == START_LAST) begin
          w_fail      = 1'b1;
          w_fail_code = ERR_START;
        end else if (w_fe) begin
          w_data_out_nx = r_byte[0];
          w_idx_nx      = 4'd1;
          w_cnt_nx      = '0;
          w_state_nx    = ST_DATA;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      ST_DATA: begin
        if (w_frame_to) begin
          w_fail      = 1'b1;
          w_fail_code = ERR_FRAME;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
          if (w_fe) begin
            if (r_idx == 4'd8) begin
              w_data_out_nx = r_par;
              w_state_nx    = ST_PARITY;
            end else begin
              w_data_out_nx = r_byte[r_idx[2:0]];
              w_idx_nx      = r_idx + 4'd1;
            end
          end else begin
            w_state_nx = ST_DATA;
          end
        end
      end
      ST_PARITY: begin
        if (w_frame_to) begin
          w_fail      = 1'b1;
          w_fail_code = ERR_FRAME;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
          if (w_fe) begin
            w_data_out_nx = 1'b1;
            w_state_nx    = ST_STOP;
          end else begin
            w_state_nx = ST_PARITY;
          end
        end
      end
      ST_STOP: begin
        if (w_frame_to) begin
          w_fail      = 1'b1;
          w_fail_code = ERR_FRAME;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
          if (w_fe) begin
            w_data_en_nx = 1'b0;
            w_state_nx   = ST_ACK_WAIT;
          end else begin
            w_state_nx = ST_STOP;
          end
        end
      end
      ST_ACK_WAIT: begin
        if (w_frame_to) begin
          w_fail      = 1'b1;
          w_fail_code = ERR_FRAME;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
          if (w_fe) begin
            if (!w_data_s) begin
              w_state_nx = ST_ACK_RELEASE;
            end else begin
              w_fail      = 1'b1;
              w_fail_code = ERR_NACK;
            end
          end else begin
            w_state_nx = ST_ACK_WAIT;
          end
        end
      end
      ST_ACK_RELEASE: begin
        if (w_frame_to) begin
          w_fail      = 1'b1;
          w_fail_code = ERR_FRAME;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
          if (w_clk_s && w_data_s) begin
            w_sent_nx  = 1'b1;
            w_state_nx = ST_IDLE;
          end else begin
            w_state_nx = ST_ACK_RELEASE;
          end
        end
      end
      default: begin
        w_data_en_nx = 1'b0;
        w_state_nx   = ST_IDLE;
      end
    endcase

    // any failure releases the data line; either retry or report
    if (w_fail) begin
      w_data_en_nx  = 1'b0;
      w_data_out_nx = 1'b0;
`ifdef PS2_TX_RETRY_EN
      if (r_retry < RW'(MAX_RETRIES)) begin
        w_retry_nx = r_retry + RW'(1);
        w_cnt_nx   = '0;
        w_state_nx = ST_INHIBIT;
      end else begin
        w_error_nx    = 1'b1;
        w_err_code_nx = w_fail_code;
        w_state_nx    = ST_IDLE;
      end
`else
      w_error_nx    = 1'b1;
      w_err_code_nx = w_fail_code;
      w_state_nx    = ST_IDLE;
`endif
    end else begin
      w_error_nx = 1'b0;
    end
  end

  // state, datapath and registered outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_idx      <= 4'd0;
      r_byte     <= 8'h00;
      r_par      <= 1'b0;
      r_clk_en   <= 1'b0;
      r_data_out <= 1'b0;
      r_data_en  <= 1'b0;
      r_busy     <= 1'b0;
      r_sent     <= 1'b0;
      r_error    <= 1'b0;
      r_err_code <= 2'b00;
`ifdef PS2_TX_RETRY_EN
      r_retry    <= '0;
`endif
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_idx      <= w_idx_nx;
      r_byte     <= w_byte_nx;
      r_par      <= w_par_nx;
      r_clk_en   <= (w_state_nx == ST_INHIBIT);
      r_data_out <= w_data_out_nx;
      r_data_en  <= w_data_en_nx;
      r_busy     <= (w_state_nx != ST_IDLE);
      r_sent     <= w_sent_nx;
      r_error    <= w_error_nx;
      r_err_code <= w_err_code_nx;
`ifdef PS2_TX_RETRY_EN
      r_retry    <= w_retry_nx;
`endif
    end
  end

  assign CLK_PS2_OUT_EN  = r_clk_en;
  assign DATA_PS2_OUT    = r_data_out;
  assign DATA_PS2_OUT_EN = r_data_en;
  assign BUSY            = r_busy;
  assign BYTE_SENT       = r_sent;
  assign ERROR           = r_error;
  assign ERR_CODE        = r_err_code;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx at CLK_FREQ_HZ = 1 MHz, with an
// open-collector line model and a 12.5 kHz device model.

module tb_ps2_host_tx;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       SEND_BYTE = 1'b0;
  logic [7:0] BYTE_TO_SEND = 8'h00;
  logic       CLK_PS2_OUT_EN, DATA_PS2_OUT, DATA_PS2_OUT_EN;
  logic       BUSY, BYTE_SENT, ERROR;
  logic [1:0] ERR_CODE;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       clk_line, data_line;

  int checks = 0;
  int errors = 0;
  int sent_cnt = 0;
  int err_cnt = 0;
  int inh_phases = 0;
  int inh_run = 0;
  int last_inh_len = 0;
  logic prev_clk_en = 1'b0;

  assign clk_line  = dev_clk & ~CLK_PS2_OUT_EN;
  assign data_line = (DATA_PS2_OUT_EN ? DATA_PS2_OUT : 1'b1) & dev_data;

  ps2_host_tx #(
    .CLK_FREQ_HZ(1_000_000), .INHIBIT_US(100), .START_TIMEOUT_US(500),
    .FRAME_TIMEOUT_US(2000), .SYNC_STAGES(2), .MAX_RETRIES(3)
  ) dut (
    .CLK(CLK), .RESET(RESET), .CLK_PS2_IN(clk_line), .CLK_PS2_OUT_EN(CLK_PS2_OUT_EN),
    .DATA_PS2_IN(data_line), .DATA_PS2_OUT(DATA_PS2_OUT), .DATA_PS2_OUT_EN(DATA_PS2_OUT_EN),
    .SEND_BYTE(SEND_BYTE), .BYTE_TO_SEND(BYTE_TO_SEND), .BUSY(BUSY),
    .BYTE_SENT(BYTE_SENT), .ERROR(ERROR), .ERR_CODE(ERR_CODE)
  );

  always #5 CLK = ~CLK;

  // pulse and inhibit-phase monitor
  always @(negedge CLK) begin
    if (BYTE_SENT) sent_cnt <= sent_cnt + 1;
    if (ERROR) err_cnt <= err_cnt + 1;
    if (CLK_PS2_OUT_EN && !prev_clk_en) begin
      inh_phases <= inh_phases + 1;
      inh_run <= 1;
    end else if (CLK_PS2_OUT_EN) begin
      inh_run <= inh_run + 1;
    end else if (prev_clk_en) begin
      last_inh_len <= inh_run;
    end
    prev_clk_en <= CLK_PS2_OUT_EN;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send(input logic [7:0] b);
    SEND_BYTE = 1'b1;
    BYTE_TO_SEND = b;
    tick(1);
    SEND_BYTE = 1'b0;
  endtask

  // device: waits for the request, then produces n_edges falling edges
  task automatic device(input int n_edges, input logic ack_bit, input int repulse_edge,
                        output logic [10:0] bits, output logic ok);
    int k;
    bits = '0;
    ok = 1'b0;
    k = 0;
    while (!(DATA_PS2_OUT_EN && !CLK_PS2_OUT_EN) && k < 1000) begin
      tick(1);
      k++;
    end
    if (k < 1000) begin
      ok = 1'b1;
      for (int i = 0; i < n_edges; i++) begin
        if (i == 11) dev_data = ack_bit;
        if (i == repulse_edge) begin
          SEND_BYTE = 1'b1;
          BYTE_TO_SEND = 8'hAA;
          tick(1);
          SEND_BYTE = 1'b0;
          tick(39);
        end else begin
          tick(40);
        end
        if (i < 11) bits[i] = data_line;
        dev_clk = 1'b0;
        tick(40);
        dev_clk = 1'b1;
        dev_data = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    tick(3);
    checks++;
    if ({CLK_PS2_OUT_EN, DATA_PS2_OUT, DATA_PS2_OUT_EN, BUSY, BYTE_SENT, ERROR, ERR_CODE} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 00000000",
               {CLK_PS2_OUT_EN, DATA_PS2_OUT, DATA_PS2_OUT_EN, BUSY, BYTE_SENT, ERROR, ERR_CODE});
    end
    RESET = 1'b0;
    tick(5);
    checks++;
    if ({CLK_PS2_OUT_EN, DATA_PS2_OUT_EN, BUSY} !== 3'b000) begin
      errors++;
      $display("FAIL idle_after_reset: got %b expected 000", {CLK_PS2_OUT_EN, DATA_PS2_OUT_EN, BUSY});
    end
  endtask

  task automatic test_frame(input string name, input logic [7:0] b, input logic [10:0] exp_bits,
                            input logic check_inhibit);
    logic [10:0] bits;
    logic ok;
    int s0, e0;
    s0 = sent_cnt;
    e0 = err_cnt;
    send(b);
    checks++;
    if (BUSY !== 1'b1) begin
      errors++;
      $display("FAIL %s_busy_rise: got %b expected 1", name, BUSY);
    end
    device(12, 1'b0, -1, bits, ok);
    checks++;
    if (ok !== 1'b1 || bits !== exp_bits) begin
      errors++;
      $display("FAIL %s_bits: got %b (req %b) expected %b", name, bits, ok, exp_bits);
    end
    if (check_inhibit) begin
      checks++;
      if (last_inh_len != 100) begin
        errors++;
        $display("FAIL %s_inhibit_len: got %0d expected 100", name, last_inh_len);
      end
    end
    tick(10);
    checks++;
    if (sent_cnt - s0 != 1 || err_cnt != e0 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL %s_done: got sent %0d err %0d busy %b expected 1 0 0",
               name, sent_cnt - s0, err_cnt - e0, BUSY);
    end
  endtask

  task automatic test_start_timeout();
    int k, n;
    send(8'h12);
    k = 0;
    while (!DATA_PS2_OUT_EN && k < 300) begin tick(1); k++; end
    n = 0;
    while (!ERROR && n < 1000) begin tick(1); n++; end
    checks++;
    if (n < 500 || n > 501) begin
      errors++;
      $display("FAIL start_to_time: got %0d expected 500..501", n);
    end
    checks++;
    if ({ERROR, ERR_CODE, CLK_PS2_OUT_EN, DATA_PS2_OUT_EN, BUSY} !== 6'b101000) begin
      errors++;
      $display("FAIL start_to_outputs: got %b expected 101000",
               {ERROR, ERR_CODE, CLK_PS2_OUT_EN, DATA_PS2_OUT_EN, BUSY});
    end
    tick(20);
    checks++;
    if (ERR_CODE !== 2'b01 || ERROR !== 1'b0) begin
      errors++;
      $display("FAIL err_code_hold: got %b/%b expected 01/0", ERR_CODE, ERROR);
    end
  endtask

  task automatic test_frame_timeout();
    logic [10:0] bits;
    logic ok;
    int n;
    send(8'h5A);
    checks++;
    if (ERR_CODE !== 2'b00) begin
      errors++;
      $display("FAIL err_code_clear: got %b expected 00", ERR_CODE);
    end
    device(5, 1'b0, -1, bits, ok);
    n = 0;
    while (!ERROR && n < 3000) begin tick(1); n++; end
    checks++;
    if (ok !== 1'b1 || n < 1630 || n > 1660) begin
      errors++;
      $display("FAIL frame_to_time: got %0d expected 1630..1660", n);
    end
    checks++;
    if ({ERROR, ERR_CODE, CLK_PS2_OUT_EN, DATA_PS2_OUT_EN, BUSY} !== 6'b110000) begin
      errors++;
      $display("FAIL frame_to_outputs: got %b expected 110000",
               {ERROR, ERR_CODE, CLK_PS2_OUT_EN, DATA_PS2_OUT_EN, BUSY});
    end
    tick(5);
  endtask

  task automatic test_nack();
    logic [10:0] bits;
    logic ok;
    int s0, e0;
    s0 = sent_cnt;
    e0 = err_cnt;
    send(8'h3C);
    device(12, 1'b1, -1, bits, ok);
    tick(10);
    checks++;
    if (ok !== 1'b1 || err_cnt - e0 != 1 || sent_cnt != s0) begin
      errors++;
      $display("FAIL nack_pulses: got err %0d sent %0d expected 1 0", err_cnt - e0, sent_cnt - s0);
    end
    checks++;
    if (ERR_CODE !== 2'b11 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL nack_code: got %b busy %b expected 11 0", ERR_CODE, BUSY);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] bits;
    logic ok;
    int s0, p0;
    s0 = sent_cnt;
    p0 = inh_phases;
    send(8'h96);
    device(12, 1'b0, 4, bits, ok);
    checks++;
    if (ok !== 1'b1 || bits !== 11'b1_1_10010110_0) begin
      errors++;
      $display("FAIL b2b_bits: got %b expected 11110010110", bits);
    end
    tick(300);
    checks++;
    if (sent_cnt - s0 != 1 || inh_phases - p0 != 1 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ignored: got sent %0d inhibits %0d busy %b expected 1 1 0",
               sent_cnt - s0, inh_phases - p0, BUSY);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [10:0] bits;
    logic ok;
    int s0, e0, p0;
    s0 = sent_cnt;
    e0 = err_cnt;
    p0 = inh_phases;
    send(8'h42);
    device(4, 1'b0, -1, bits, ok);
    checks++;
    if (ok !== 1'b1 || DATA_PS2_OUT_EN !== 1'b1 || BUSY !== 1'b1) begin
      errors++;
      $display("FAIL mid_frame_active: got en %b busy %b expected 1 1", DATA_PS2_OUT_EN, BUSY);
    end
    RESET = 1'b1;
    tick(1);
    RESET = 1'b0;
    checks++;
    if ({CLK_PS2_OUT_EN, DATA_PS2_OUT, DATA_PS2_OUT_EN, BUSY, BYTE_SENT, ERROR, ERR_CODE} !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %b expected 00000000",
               {CLK_PS2_OUT_EN, DATA_PS2_OUT, DATA_PS2_OUT_EN, BUSY, BYTE_SENT, ERROR, ERR_CODE});
    end
    tick(300);
    checks++;
    if (sent_cnt != s0 || err_cnt != e0 || inh_phases - p0 != 1 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_quiet: got sent %0d err %0d inhibits %0d expected 0 0 1",
               sent_cnt - s0, err_cnt - e0, inh_phases - p0);
    end
  endtask

`ifdef PS2_TX_RETRY_EN
  task automatic test_retry();
    logic [10:0] bits;
    logic ok1, ok2, ok3;
    int s0, e0, p0;
    s0 = sent_cnt;
    e0 = err_cnt;
    p0 = inh_phases;
    send(8'h77);
    device(12, 1'b1, -1, bits, ok1);
    device(12, 1'b1, -1, bits, ok2);
    device(12, 1'b0, -1, bits, ok3);
    tick(10);
    checks++;
    if (!(ok1 && ok2 && ok3) || inh_phases - p0 != 3 || sent_cnt - s0 != 1 || err_cnt != e0) begin
      errors++;
      $display("FAIL retry: got inhibits %0d sent %0d err %0d expected 3 1 0",
               inh_phases - p0, sent_cnt - s0, err_cnt - e0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_frame("f4", 8'hF4, 11'b1_0_11110100_0, 1'b1);
    test_frame("b00", 8'h00, 11'b1_1_00000000_0, 1'b0);
    test_frame("bff", 8'hFF, 11'b1_1_11111111_0, 1'b0);
    test_frame("b01", 8'h01, 11'b1_0_00000001_0, 1'b0);
`ifndef PS2_TX_RETRY_EN
    test_start_timeout();
    test_frame_timeout();
    test_nack();
`else
    test_retry();
`endif
    test_back_to_back();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
